// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: bundle layout and the per-bundle PC stride.
package fetch_pkg;

   localparam int unsigned FETCH_WIDTH  = 2;
   localparam logic [31:0] BUNDLE_BYTES = 32'(4 * FETCH_WIDTH);

   typedef struct packed {
      logic [31:0]                  pc;
      logic [FETCH_WIDTH-1:0][31:0] instr;
   } fetch_bundle_t;

endpackage

// File: rtl/fetch_bundle_queue_bundle_fifo.sv
// Small circular FIFO of fetch bundles with a flush that drops every entry at once.
module bundle_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  fetch_bundle_t push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] occupancy,
   output fetch_bundle_t head
);

   localparam int unsigned PW = $clog2(DEPTH);

   fetch_bundle_t mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          pop_ok;

   // Popping an empty queue is ignored so the pointers can never cross.
   assign pop_ok = pop && (occupancy != '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop_ok})
            2'b10:   occupancy <= occupancy + CW'(1);
            2'b01:   occupancy <= occupancy - CW'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_bundle_queue.sv
// Fetch PC owner and bundle queue between instruction memory and the issue controller.
module fetch_bundle_queue #(
   parameter int unsigned FETCH_WIDTH = fetch_pkg::FETCH_WIDTH,
   parameter int unsigned DEPTH       = 4,
   parameter logic [31:0] START_PC    = 32'h0000_3000,
   localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic [31:0]                  imem_addr,
   input  logic [FETCH_WIDTH-1:0][31:0] imem_data,
   input  logic                         redirect_valid,
   input  logic [31:0]                  redirect_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_pc,
   output logic [FETCH_WIDTH-1:0][31:0] out_instr,
   output logic [CW-1:0]                occupancy
);

   import fetch_pkg::*;

   logic [31:0]   fetch_pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic          fire;
   logic [CW:0]   credit_used;
   fetch_bundle_t push_data;
   fetch_bundle_t head;

   assign imem_addr = fetch_pc;

   // Credit counts registered occupancy plus the outstanding request, so the
   // response slot is always reserved before the request is issued.
   assign credit_used = {1'b0, occupancy} + (CW+1)'(inflight);
   assign fire        = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= START_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= fire;
         if (fire) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + BUNDLE_BYTES;
         end
      end
   end

   assign push_data = '{pc: inflight_pc, instr: imem_data};

   bundle_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight),
      .push_data (push_data),
      .pop       (out_valid && out_ready),
      .flush     (redirect_valid),
      .occupancy (occupancy),
      .head      (head)
   );

   assign out_valid = (occupancy != '0);
   assign out_pc    = out_valid ? head.pc    : '0;
   assign out_instr = out_valid ? head.instr : '0;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed bench: scoreboard of expected bundle PCs, popped by a monitor on each accepted handshake.
module tb_fetch_bundle_queue;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       imem_addr;
   logic [1:0][31:0]  imem_data;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_pc;
   logic [1:0][31:0]  out_instr;
   logic [2:0]        occupancy;

   int          errors = 0;
   int          checks = 0;
   int          pops   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   fetch_bundle_queue #(.FETCH_WIDTH(2), .DEPTH(4), .START_PC(32'h0000_3000)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .occupancy      (occupancy)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: the word stored at byte address A is A itself.
   always_ff @(posedge clk) imem_data <= {imem_addr + 32'd4, imem_addr};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_exp(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(8 * i));
   endtask

   // Release reset and check the fixed startup timing.
   task automatic startup();
      reset = 1'b0;
      tick();
      chk("su_valid_c1", 32'(out_valid), 0);
      chk("su_addr_c1", imem_addr, 32'h3008);
      tick();
      chk("su_valid_c2", 32'(out_valid), 1);
      chk("su_pc_c2", out_pc, 32'h3000);
      chk("su_occ_c2", 32'(occupancy), 1);
   endtask

   // Bundles accepted alongside reset or a redirect are killed and not scored.
   always @(negedge clk) begin
      if (!reset && !redirect_valid && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got pc %h expected no bundle", out_pc);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("sb_pc", out_pc, mon_exp);
            chk("sb_instr0", out_instr[0], mon_exp);
            chk("sb_instr1", out_instr[1], mon_exp + 32'd4);
            pops++;
         end
      end
   end

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;
      load_exp(32'h3000);
      repeat (3) tick();
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_addr", imem_addr, 32'h3000);
      chk("rst_pc", out_pc, 0);
      chk("rst_instr", out_instr[0], 0);

      startup();
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("stream_valid", 32'(out_valid), 1);
         chk("stream_pc", out_pc, 32'h3000 + 32'(8 * i));
      end

      // Backpressure from a fresh start: queue fills, fetch stalls.
      reset     = 1'b1;
      out_ready = 1'b0;
      load_exp(32'h3000);
      tick();
      chk("midrst_occ", 32'(occupancy), 0);
      chk("midrst_valid", 32'(out_valid), 0);
      reset = 1'b0;
      repeat (10) tick();
      chk("hold_occ", 32'(occupancy), 4);
      chk("hold_addr", imem_addr, 32'h3020);
      chk("hold_pc", out_pc, 32'h3000);

      // Single-cycle ready pulse earns exactly one extra fetch.
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pulse_occ_a", 32'(occupancy), 3);
      chk("pulse_addr_a", imem_addr, 32'h3020);
      chk("pulse_head", out_pc, 32'h3008);
      tick();
      chk("pulse_occ_b", 32'(occupancy), 3);
      chk("pulse_addr_b", imem_addr, 32'h3028);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("pulse_occ_full", 32'(occupancy), 4);
         chk("pulse_addr_hold", imem_addr, 32'h3028);
      end
      out_ready = 1'b1;
      repeat (12) tick();

      // Redirect while a response is arriving and the consumer is accepting.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3400;
      load_exp(32'h3400);
      tick();
      redirect_valid = 1'b0;
      chk("redir_occ", 32'(occupancy), 0);
      chk("redir_valid_t1", 32'(out_valid), 0);
      chk("redir_addr", imem_addr, 32'h3400);
      tick();
      chk("redir_valid_t2", 32'(out_valid), 0);
      tick();
      chk("redir_valid_t3", 32'(out_valid), 1);
      chk("redir_pc_t3", out_pc, 32'h3400);
      repeat (4) tick();

      // Back-to-back redirects: only the second target may ever be delivered.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3100;
      load_exp(32'h3200);
      tick();
      redirect_pc = 32'h3200;
      tick();
      redirect_valid = 1'b0;
      chk("b2b_occ", 32'(occupancy), 0);
      chk("b2b_addr", imem_addr, 32'h3200);
      tick();
      chk("b2b_valid_t3", 32'(out_valid), 0);
      tick();
      chk("b2b_valid_t4", 32'(out_valid), 1);
      chk("b2b_pc_t4", out_pc, 32'h3200);
      repeat (4) tick();

      // Reset with three bundles queued, then identical restart.
      reset = 1'b1;
      load_exp(32'h3000);
      tick();
      reset     = 1'b0;
      out_ready = 1'b0;
      repeat (4) tick();
      chk("part_occ", 32'(occupancy), 3);
      reset = 1'b1;
      tick();
      chk("part_rst_occ", 32'(occupancy), 0);
      chk("part_rst_valid", 32'(out_valid), 0);
      chk("part_rst_addr", imem_addr, 32'h3000);
      out_ready = 1'b1;
      load_exp(32'h3000);
      startup();
      repeat (4) tick();

      chk("sb_activity", 32'(pops > 20), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_bundle_queue.md
Name: fetch_bundle_queue

Overview:
- Decoupling stage between instruction_memory and issue_controller.
- Owns the fetch PC and drives the instruction memory address.
- Captures each FETCH_WIDTH-wide instruction bundle, together with its PC, into a small FIFO.
- Presents the FIFO head to the issue controller with a valid/ready handshake.
- A PC redirect (branch mispredict, JR redirect, rollback) flushes all queued and in-flight bundles and restarts fetch at the new PC.

Parameters:
- FETCH_WIDTH, 2, instructions per bundle; each bundle is consecutive 32-bit words.
- DEPTH, 4, bundle entries in the queue; power of two, at least 2.
- START_PC, 32'h0000_3000, fetch PC after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address of the bundle being fetched.
- imem_data  in  FETCH_WIDTH*32 (packed [FETCH_WIDTH-1:0][31:0])  bundle read from imem; valid one cycle after imem_addr.
- redirect_valid  in  1  flush everything and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; word aligned.
- out_valid  out  1  queue head holds a bundle.
- out_ready  in  1  consumer accepts the head bundle this cycle.
- out_pc  out  32  PC of instruction slot 0 of the head bundle.
- out_instr  out  FETCH_WIDTH*32 (packed)  head bundle instructions; slot k is at out_pc+4k.
- occupancy  out  $clog2(DEPTH+1)  number of valid queue entries.

Behaviour:
- Reset: fetch_pc=START_PC, inflight=0, rd/wr pointers=0, occupancy=0, out_valid=0. out_pc/out_instr are 0 while out_valid=0. imem_addr=START_PC.
- imem_addr = fetch_pc, combinationally from the register.
- Fetch fires in a cycle when all of the following hold: not reset, not redirect_valid, and (occupancy + inflight) < DEPTH.
  - Registered occupancy and inflight values are used; same-cycle dequeue earns no credit.
  - On fire: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc + 4*FETCH_WIDTH (32-bit wrap-around, no error).
  - Otherwise inflight<=0.
- Response: in the cycle after a fire (inflight=1), imem_data and inflight_pc are written to entry wr_ptr and wr_ptr increments mod DEPTH.
  - The credit check guarantees the queue can never overflow.
- Dequeue: out_valid && out_ready moves rd_ptr forward mod DEPTH.
  - out_* reflect entry rd_ptr combinationally.
  - Head is held stable while out_valid && !out_ready.
  - out_ready while out_valid=0 is ignored.
- Simultaneous enqueue and dequeue: occupancy is unchanged, pointers both advance.
- Redirect, cycle t:
  - Pointers and occupancy clear and inflight<=0, so a response arriving at t is dropped.
  - A dequeue at t is discarded; the consumer must treat a bundle accepted alongside a redirect as killed.
  - fetch_pc<=redirect_pc and no fire occurs at t.
  - t+1: out_valid=0, fire at redirect_pc. t+2: response enqueued. t+3: out_valid=1 with out_pc=redirect_pc.
- Back-to-back redirects: the last one wins; each restarts the sequence above.
- Startup latency: reset released before cycle 0 → fire at cycle 0 (addr START_PC), enqueue at cycle 1, out_valid=1 at cycle 2.
- Throughput: one bundle per cycle sustained when out_ready=1 continuously.
- Reset asserted mid-operation overrides everything, including redirect; in-flight data is dropped.
- Empty: out_valid=0. Full: occupancy=DEPTH, no fire until a dequeue has been registered.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef fetch_bundle_t {logic [31:0] pc; logic [FETCH_WIDTH-1:0][31:0] instr;}
  - constant BUNDLE_BYTES = 4*FETCH_WIDTH.
- One natural sub-module: bundle_fifo.
  - Parameterised over DEPTH, storing fetch_bundle_t.
  - Ports: push, pop, flush, occupancy, head.
- Fetch PC, in-flight tracking and the credit check stay in the top.

Test Plan:
- Reset release with imem modelled as 1-cycle sync ROM (word at A = A), out_ready=1 → out_valid rises at cycle 2.
  - out_pc=0x3000, instr={0x3004,0x3000}.
  - Next cycles give out_pc 0x3008, 0x3010, 0x3018 with no bubbles.
- Hold out_ready=0 for 10 cycles → occupancy saturates at 4, imem_addr freezes at 0x3020, head stays at 0x3000.
  - Release → bundles 0x3000..0x3018 drain in order, then fetch resumes at 0x3020 with no gaps or duplicates.
- Full queue, then pulse out_ready for 1 cycle → exactly one extra fire happens one cycle later and occupancy returns to 4.
- redirect_valid=1, redirect_pc=0x3400, asserted at a cycle with out_ready=1 and a response arriving → that response is dropped, occupancy=0 next cycle.
  - out_valid=1 with out_pc=0x3400 exactly 3 cycles after the redirect.
- Redirects on consecutive cycles to 0x3100 then 0x3200 → no bundle from 0x3100 ever appears; the first bundle out is 0x3200.
- reset pulsed while the queue holds 3 bundles → occupancy=0 and out_valid=0 next cycle; fetch restarts at 0x3000 with identical startup timing.
